// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite ROM arbiter.
// Geometry defaults match the 60x60, 4-bit-index sprite ROM.
package sprite_pkg;

  localparam int unsigned SPRITE_W      = 60;
  localparam int unsigned SPRITE_H      = 60;
  localparam int unsigned ADDR_W        = 12;
  localparam int unsigned PIX_W         = 4;
  localparam int unsigned COORD_W       = 6;
  localparam int unsigned N_REQ_DEFAULT = 4;
  localparam int unsigned ID_W          = $clog2(N_REQ_DEFAULT);

  localparam logic [PIX_W-1:0] TRANSPARENT_IDX = '0;

  typedef logic [ID_W-1:0] req_id_t;

endpackage

// File: rtl/sprite_rom_if.sv
// Request, ROM and response bundle between draw engines and the sprite ROM arbiter.
// The slave modport is the arbiter; master is the requester/ROM side.
interface sprite_rom_if
  import sprite_pkg::*;
#(
  parameter int unsigned N_REQ  = sprite_pkg::N_REQ_DEFAULT,
  parameter int unsigned ADDR_W = sprite_pkg::ADDR_W,
  parameter int unsigned PIX_W  = sprite_pkg::PIX_W
);
  localparam int unsigned IdW = $clog2(N_REQ);

  logic [N_REQ-1:0]              req;
  logic [N_REQ-1:0][COORD_W-1:0] req_x;
  logic [N_REQ-1:0][COORD_W-1:0] req_y;
  logic [N_REQ-1:0]              req_flip;
  logic [N_REQ-1:0]              gnt;
  logic [ADDR_W-1:0]             rom_addr;
  logic [PIX_W-1:0]              rom_data;
  logic                          rsp_valid;
  logic [IdW-1:0]                rsp_id;
  logic [PIX_W-1:0]              rsp_index;

  modport slave (
    input  req, req_x, req_y, req_flip, rom_data,
    output gnt, rom_addr, rsp_valid, rsp_id, rsp_index
  );

  modport master (
    output req, req_x, req_y, req_flip, rom_data,
    input  gnt, rom_addr, rsp_valid, rsp_id, rsp_index
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last grant and wraps.
// Produces a one-hot grant and its encoded index; no grant when req is zero.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] id
);
  localparam int unsigned IdW = $clog2(N);

  logic        found;
  int unsigned idx;

  always_comb begin
    gnt   = '0;
    id    = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(last) + i) % N;
      if (!found && req[IdW'(idx)]) begin
        found            = 1'b1;
        gnt[IdW'(idx)]   = 1'b1;
        id               = IdW'(idx);
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin share of the sprite ROM read port with (x, y) to linear address conversion
// and a fixed two-cycle response pipeline. Define SPRITE_FLIP_EN to enable horizontal mirroring.
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int unsigned N_REQ    = sprite_pkg::N_REQ_DEFAULT,
  parameter int unsigned SPRITE_W = sprite_pkg::SPRITE_W,
  parameter int unsigned SPRITE_H = sprite_pkg::SPRITE_H,
  parameter int unsigned ADDR_W   = sprite_pkg::ADDR_W,
  parameter int unsigned PIX_W    = sprite_pkg::PIX_W
) (
  input  logic           clk,
  input  logic           rst,
  sprite_rom_if.slave    bus
);
  localparam int unsigned IdW = $clog2(N_REQ);

  logic [IdW-1:0]     last_gnt;
  logic [IdW-1:0]     gnt_id;
  logic               any_gnt;
  logic [COORD_W-1:0] x_sel;
  logic [COORD_W-1:0] y_sel;
  int unsigned        xi;
  int unsigned        yi;
  int unsigned        xm;
  logic               oob;
  logic [ADDR_W-1:0]  addr_d;

  logic               v1;
  logic [IdW-1:0]     id1;
  logic               oob1;
  logic               oob2;

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr_arbiter (
    .req  (bus.req),
    .last (last_gnt),
    .gnt  (bus.gnt),
    .id   (gnt_id)
  );

  assign any_gnt = |bus.gnt;

  // Bounds are judged on the raw column, before any mirroring.
  always_comb begin
    x_sel  = bus.req_x[gnt_id];
    y_sel  = bus.req_y[gnt_id];
    xi     = 32'(x_sel);
    yi     = 32'(y_sel);
    oob    = (xi >= SPRITE_W) || (yi >= SPRITE_H);
`ifdef SPRITE_FLIP_EN
    xm     = bus.req_flip[gnt_id] ? (SPRITE_W - 1 - xi) : xi;
`else
    xm     = xi;
`endif
    addr_d = ADDR_W'(yi * SPRITE_W + xm);
  end

`ifdef SPRITE_FLIP_EN
`else
  logic unused_flip;
  assign unused_flip = ^bus.req_flip;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt      <= IdW'(N_REQ - 1);
      bus.rom_addr  <= '0;
      v1            <= 1'b0;
      id1           <= '0;
      oob1          <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      oob2          <= 1'b0;
    end else begin
      if (any_gnt) begin
        last_gnt <= gnt_id;
      end
      // Out-of-bounds fetches leave the ROM address parked.
      if (any_gnt && !oob) begin
        bus.rom_addr <= addr_d;
      end
      v1            <= any_gnt;
      id1           <= gnt_id;
      oob1          <= any_gnt && oob;
      bus.rsp_valid <= v1;
      bus.rsp_id    <= id1;
      oob2          <= oob1;
    end
  end

  assign bus.rsp_index = oob2 ? PIX_W'(TRANSPARENT_IDX) : bus.rom_data;

endmodule
